game_flow_fsm: RTL and testbench

GAME_FLOW_FSM -- requirements
Module: game_flow_fsm

---
 rtl/game_flow_fsm.sv | 149 ++++++++++++++
 tb/tb_game_flow_fsm.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/game_flow_fsm.sv
// Game flow controller: start / play / respawn / level-clear / game-over sequencing.
// Optional pause state is compiled in with `define GAME_FLOW_PAUSE_EN.
module game_flow_fsm #(
  parameter int          NUM_LEVELS  = 4,
  parameter int          NUM_LIVES   = 3,
  parameter int          RESPAWN_CYC = 100000000,
  parameter logic [8:0]  PAUSE_CODE  = 9'h076,
  localparam int         LVL_W       = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  localparam int         LIFE_W      = $clog2(NUM_LIVES + 1)
) (
  input  logic              clk_main,
  input  logic              rst_n,
  input  logic              is_hit,
  input  logic              is_clear,
  input  logic [511:0]      key_down,
  input  logic [8:0]        last_change,
  output logic              me_en,
  output logic              enemy_en,
  output logic [2:0]        show_text,
  output logic [LVL_W-1:0]  level,
  output logic [LIFE_W-1:0] lives,
  output logic              level_load,
  output logic [2:0]        state
);
  localparam int CNT_W = (RESPAWN_CYC > 1) ? $clog2(RESPAWN_CYC) : 1;
  localparam logic [LVL_W-1:0] LAST_LVL = LVL_W'(NUM_LEVELS - 1);

  typedef enum logic [2:0] {
    ST_READY    = 3'd0,
    ST_PLAY     = 3'd1,
    ST_OVER     = 3'd2,
    ST_COMPLETE = 3'd3,
    ST_PAUSE    = 3'd4,
    ST_LCLEAR   = 3'd5,
    ST_RESPAWN  = 3'd6
  } state_t;

  state_t            st_q, st_d;
  logic [LVL_W-1:0]  lvl_q, lvl_d;
  logic [LIFE_W-1:0] lives_q, lives_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              load_q, load_d;
  logic              key_r, hit_r, clr_r;

  logic kd_cur, kp, pp, hit_ev, clr_ev;
  assign kd_cur = key_down[last_change];
  assign kp     = kd_cur & ~key_r;
  assign pp     = kp & (last_change == PAUSE_CODE);
  assign hit_ev = is_hit & ~hit_r;
  assign clr_ev = is_clear & ~clr_r;

  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_READY;
      lvl_q   <= '0;
      lives_q <= LIFE_W'(NUM_LIVES);
      cnt_q   <= '0;
      load_q  <= 1'b0;
      key_r   <= 1'b0;
      hit_r   <= 1'b0;
      clr_r   <= 1'b0;
    end else begin
      st_q    <= st_d;
      lvl_q   <= lvl_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      // edge registers track in every state so events resume cleanly after pause/respawn
      key_r   <= kd_cur;
      hit_r   <= is_hit;
      clr_r   <= is_clear;
    end
  end

  always_comb begin
    st_d    = st_q;
    lvl_d   = lvl_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    load_d  = 1'b0;
    case (st_q)
      ST_READY: if (kp) begin
        st_d    = ST_PLAY;
        lvl_d   = '0;
        lives_d = LIFE_W'(NUM_LIVES);
        load_d  = 1'b1;
      end
      ST_PLAY: begin
        if (hit_ev) begin
          if (lives_q > LIFE_W'(1)) begin
            lives_d = lives_q - LIFE_W'(1);
            cnt_d   = CNT_W'(RESPAWN_CYC - 1);
            st_d    = ST_RESPAWN;
          end else begin
            lives_d = '0;
            st_d    = ST_OVER;
          end
        end else if (clr_ev) begin
          st_d = (lvl_q < LAST_LVL) ? ST_LCLEAR : ST_COMPLETE;
        end
`ifdef GAME_FLOW_PAUSE_EN
        else if (pp) begin
          st_d = ST_PAUSE;
        end
`endif
      end
`ifdef GAME_FLOW_PAUSE_EN
      ST_PAUSE: if (pp) st_d = ST_PLAY;
`endif
      ST_LCLEAR: if (kp) begin
        st_d   = ST_PLAY;
        load_d = 1'b1;
        if (lvl_q < LAST_LVL) lvl_d = lvl_q + LVL_W'(1);
      end
      ST_RESPAWN: begin
        if (cnt_q == '0) begin
          st_d   = ST_PLAY;
          load_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_OVER, ST_COMPLETE: if (kp) st_d = ST_READY;
      default: st_d = ST_READY;
    endcase
  end

  always_comb begin
    show_text = 3'd0;
    case (st_q)
      ST_READY:    show_text = 3'd1;
      ST_OVER:     show_text = 3'd2;
      ST_COMPLETE: show_text = 3'd3;
`ifdef GAME_FLOW_PAUSE_EN
      ST_PAUSE:    show_text = 3'd4;
`endif
      ST_LCLEAR:   show_text = 3'd5;
      ST_RESPAWN:  show_text = 3'd6;
      default:     show_text = 3'd0;
    endcase
  end

  assign me_en      = (st_q == ST_PLAY);
  assign enemy_en   = (st_q == ST_PLAY) || (st_q == ST_RESPAWN) || (st_q == ST_OVER);
  assign level      = lvl_q;
  assign lives      = lives_q;
  assign level_load = load_q;
  assign state      = st_q;
endmodule

// File: tb/tb_game_flow_fsm.sv
// Bench for game_flow_fsm: directed scenarios plus random play against a cycle-level game model.
module tb_game_flow_fsm;
  localparam int NLV = 4, NLF = 3, RC = 10;
  localparam logic [8:0] PC = 9'h076;
`ifdef GAME_FLOW_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic         clk_main = 1'b0, rst_n = 1'b0, is_hit = 1'b0, is_clear = 1'b0;
  logic [511:0] key_down = '0;
  logic [8:0]   last_change = '0;
  logic         me_en, enemy_en, level_load;
  logic [2:0]   show_text, state;
  logic [1:0]   level, lives;

  game_flow_fsm #(.NUM_LEVELS(NLV), .NUM_LIVES(NLF), .RESPAWN_CYC(RC), .PAUSE_CODE(PC)) dut (
    .clk_main(clk_main), .rst_n(rst_n), .is_hit(is_hit), .is_clear(is_clear),
    .key_down(key_down), .last_change(last_change), .me_en(me_en), .enemy_en(enemy_en),
    .show_text(show_text), .level(level), .lives(lives), .level_load(level_load), .state(state)
  );

  always #5 clk_main = ~clk_main;

  typedef struct packed {
    logic [2:0] st; logic [1:0] lvl; logic [1:0] lf; logic ld; logic me; logic en; logic [2:0] txt;
  } obs_t;
  obs_t exp_q[$];
  int checks = 0, errors = 0, cyc = 0;

  // game model: screen codes are the debug values the state output must show
  localparam int READY = 0, PLAY = 1, OVER = 2, COMPLETE = 3, PAUSE = 4, LCLEAR = 5, RESPAWN = 6;
  int m_mode, m_lvl, m_lives, m_left;
  bit m_load, p_key, p_hit, p_clr;

  task automatic model_reset();
    m_mode = READY; m_lvl = 0; m_lives = NLF; m_left = 0; m_load = 0;
    p_key = 0; p_hit = 0; p_clr = 0;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    int txt;
    case (m_mode)
      READY: txt = 1; OVER: txt = 2; COMPLETE: txt = 3; PAUSE: txt = 4;
      LCLEAR: txt = 5; RESPAWN: txt = 6; default: txt = 0;
    endcase
    o.st = 3'(m_mode); o.lvl = 2'(m_lvl); o.lf = 2'(m_lives); o.ld = m_load;
    o.me = (m_mode == PLAY);
    o.en = (m_mode == PLAY) || (m_mode == RESPAWN) || (m_mode == OVER);
    o.txt = 3'(txt);
    return o;
  endfunction

  task automatic model_step();
    bit kd, kp, pp, hit, clr;
    kd  = key_down[last_change];
    kp  = kd && !p_key;
    pp  = kp && (last_change == PC);
    hit = is_hit && !p_hit;
    clr = is_clear && !p_clr;
    p_key = kd; p_hit = is_hit; p_clr = is_clear;
    m_load = 0;
    case (m_mode)
      READY: if (kp) begin m_mode = PLAY; m_lvl = 0; m_lives = NLF; m_load = 1; end
      PLAY: begin
        if (hit) begin
          m_lives = m_lives - 1;
          m_mode  = (m_lives == 0) ? OVER : RESPAWN;
          m_left  = RC;
        end else if (clr) m_mode = (m_lvl == NLV - 1) ? COMPLETE : LCLEAR;
        else if (pp && PAUSE_EN) m_mode = PAUSE;
      end
      PAUSE:   if (pp) m_mode = PLAY;
      LCLEAR:  if (kp) begin m_lvl = m_lvl + 1; m_mode = PLAY; m_load = 1; end
      RESPAWN: begin
        m_left = m_left - 1;
        if (m_left == 0) begin m_mode = PLAY; m_load = 1; end
      end
      default: if (kp) m_mode = READY;
    endcase
  endtask

  initial model_reset();

  always @(posedge clk_main) begin
    if (!rst_n) model_reset();
    else model_step();
    exp_q.push_back(model_obs());
  end

  always @(negedge clk_main) begin
    if (exp_q.size() > 0) begin
      obs_t e, a;
      e = exp_q.pop_front();
      a = {state, level, lives, level_load, me_en, enemy_en, show_text};
      cyc++;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs cyc %0d: got st=%0d lvl=%0d lives=%0d ld=%b me=%b en=%b txt=%0d want st=%0d lvl=%0d lives=%0d ld=%b me=%b en=%b txt=%0d",
                 cyc, a.st, a.lvl, a.lf, a.ld, a.me, a.en, a.txt, e.st, e.lvl, e.lf, e.ld, e.me, e.en, e.txt);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin @(posedge clk_main); #1; end
  endtask

  task automatic press(logic [8:0] code);
    last_change = code; key_down[code] = 1'b1; tick(1);
    key_down[code] = 1'b0; tick(1);
  endtask

  task automatic pulse_hit();
    is_hit = 1'b1; tick(2); is_hit = 1'b0; tick(1);
  endtask

  task automatic pulse_clr();
    is_clear = 1'b1; tick(2); is_clear = 1'b0; tick(1);
  endtask

  // reset lands between edges; the expectation pending for this cycle becomes the reset values
  task automatic async_reset();
    rst_n = 1'b0;
    model_reset();
    if (exp_q.size() > 0) exp_q[exp_q.size()-1] = model_obs();
    #1;
    checks++;
    if (state !== 3'd0 || lives !== 2'(NLF) || level !== 2'd0 || level_load !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got st=%0d lives=%0d lvl=%0d ld=%b want st=0 lives=%0d lvl=0 ld=0",
               state, lives, level, level_load, NLF);
    end
  endtask

  initial begin
    bit held = 0;
    tick(3); rst_n = 1'b1; tick(2);
    // long key hold in READY: a single start
    last_change = 9'h01C; key_down[9'h01C] = 1'b1; tick(20);
    key_down[9'h01C] = 1'b0; tick(2);
    // three hits, each after respawn finishes
    repeat (3) begin pulse_hit(); tick(12); end
    press(9'h029);
    // four clears through all levels to COMPLETE, then back to READY
    press(9'h01C);
    repeat (4) begin pulse_clr(); tick(1); press(9'h05A); end
    tick(2);
    // simultaneous hit and clear
    press(9'h01C);
    is_hit = 1'b1; is_clear = 1'b1; tick(2); is_hit = 1'b0; is_clear = 1'b0; tick(12);
    // pause, ignored hit, resume
    press(PC); pulse_hit(); tick(2); press(PC); tick(14);
    // reset mid-respawn
    async_reset(); tick(2); rst_n = 1'b1; tick(2);
    press(9'h01C); pulse_hit(); tick(2);
    async_reset(); tick(3); rst_n = 1'b1; tick(3);
    // random play
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 4) is_hit = ~is_hit;
      if ($urandom_range(0, 99) < 5) is_clear = ~is_clear;
      if (held) begin
        if ($urandom_range(0, 3) == 0) begin key_down[last_change] = 1'b0; held = 0; end
      end else if ($urandom_range(0, 5) == 0) begin
        last_change = ($urandom_range(0, 2) == 0) ? PC : 9'($urandom_range(0, 511));
        key_down[last_change] = 1'b1; held = 1;
      end
      if ($urandom_range(0, 999) == 0) begin async_reset(); tick(2); rst_n = 1'b1; end
      tick(1);
    end
    tick(2);
    @(negedge clk_main); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
